// File: rtl/router_pkg.sv
// Shared router definitions: check modes, default widths, address decode.
package router_pkg;

    localparam int CHK_XOR = 0;
    localparam int CHK_SUM = 1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // The all-ones address is reserved and never routed.
    function automatic logic addr_invalid(
        input logic [31:0] addr,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (addr & mask) == mask;
    endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator: XOR parity or modular sum.
module router_chk_acc
    import router_pkg::*;
#(
    parameter int W    = DEF_DATA_W,
    parameter int MODE = CHK_XOR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] nxt;

    assign nxt = (MODE == CHK_SUM) ? acc + din : acc ^ din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/router_reg_param.sv
// Router packet register stage: header latch, byte forwarding with
// full-FIFO hold, check accumulation and length checking.
module router_reg_param
    import router_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LEN_W    = DATA_W - ADDR_W,
    parameter int CHK_MODE = CHK_XOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              error,
    output logic              len_err,
    output logic [LEN_W-1:0]  pkt_len
);

    logic [DATA_W-1:0] header_byte;
    logic [DATA_W-1:0] hold_byte;
    logic [DATA_W-1:0] pkt_chk;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_din;
    logic [DATA_W-1:0] chk_now;
    logic [LEN_W:0]    count;
    logic              hdr_ok;
    logic              pay_en;
    logic              acc_en;
    logic              chk_cycle;
    logic              set_pd;

    assign hdr_ok = detect_add & pkt_valid &
        ~addr_invalid(32'(data_in[ADDR_W-1:0]), ADDR_W);

    assign pay_en    = ld_state & pkt_valid & ~full_state;
    assign acc_en    = lfd_state | pay_en;
    assign acc_din   = lfd_state ? header_byte : data_in;
    assign chk_cycle = ld_state & ~pkt_valid;

    // Compare against the check byte arriving this cycle, not last one.
    assign chk_now = chk_cycle ? data_in : pkt_chk;

    assign set_pd = ~parity_done &
        ((ld_state & ~fifo_full & ~pkt_valid) |
         (laf_state & low_pkt_valid));

    router_chk_acc #(
        .W    (DATA_W),
        .MODE (CHK_MODE)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (detect_add),
        .en    (acc_en),
        .din   (acc_din),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            header_byte   <= '0;
            hold_byte     <= '0;
            pkt_chk       <= '0;
            count         <= '0;
            dout          <= '0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            error         <= 1'b0;
            len_err       <= 1'b0;
            pkt_len       <= '0;
        end else begin
            if (hdr_ok) begin
                header_byte <= data_in;
                pkt_len     <= data_in[DATA_W-1:ADDR_W];
            end

            if (lfd_state) begin
                dout <= header_byte;
            end else if (ld_state && !fifo_full) begin
                dout <= data_in;
            end else if (ld_state) begin
                hold_byte <= data_in;
            end else if (laf_state) begin
                dout <= hold_byte;
            end

            if (chk_cycle) begin
                pkt_chk <= data_in;
            end

            if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (chk_cycle) begin
                low_pkt_valid <= 1'b1;
            end

            if (detect_add) begin
                count       <= '0;
                parity_done <= 1'b0;
                error       <= 1'b0;
                len_err     <= 1'b0;
            end else begin
                if (pay_en && count != '1) begin
                    count <= count + (LEN_W+1)'(1);
                end
                if (set_pd) begin
                    parity_done <= 1'b1;
                    error       <= (acc != chk_now);
                    len_err     <= (count != {1'b0, pkt_len});
                end
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param, XOR and SUM instances in parallel.
module tb_router_reg_param;
    import router_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       detect_add = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       lfd_state = 1'b0;

    logic [7:0] dout_x, dout_s;
    logic       pd_x, pd_s, lpv_x, lpv_s;
    logic       err_x, err_s, le_x, le_s;
    logic [5:0] len_x, len_s;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] pl [16];

    always #5 clk = ~clk;

    router_reg_param #(.CHK_MODE(CHK_XOR)) dut_x (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .lfd_state(lfd_state),
        .dout(dout_x), .parity_done(pd_x),
        .low_pkt_valid(lpv_x), .error(err_x),
        .len_err(le_x), .pkt_len(len_x)
    );

    router_reg_param #(.CHK_MODE(CHK_SUM)) dut_s (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .lfd_state(lfd_state),
        .dout(dout_s), .parity_done(pd_s),
        .low_pkt_valid(lpv_s), .error(err_s),
        .len_err(le_s), .pkt_len(len_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic flags(input string t, input logic pd,
                         input logic ex, input logic es,
                         input logic le);
        check({t, ".pd_x"}, 32'(pd_x), 32'(pd));
        check({t, ".pd_s"}, 32'(pd_s), 32'(pd));
        check({t, ".err_x"}, 32'(err_x), 32'(ex));
        check({t, ".err_s"}, 32'(err_s), 32'(es));
        check({t, ".le_x"}, 32'(le_x), 32'(le));
        check({t, ".le_s"}, 32'(le_s), 32'(le));
    endtask

    task automatic hdr(input logic [7:0] h, input logic ri,
                       input logic [5:0] el,
                       input logic [7:0] ed);
        detect_add  = 1'b1;
        pkt_valid   = 1'b1;
        data_in     = h;
        rst_int_reg = ri;
        tick;
        detect_add  = 1'b0;
        rst_int_reg = 1'b0;
        check("hdr.len_x", 32'(len_x), 32'(el));
        check("hdr.len_s", 32'(len_s), 32'(el));
        flags("hdr", 1'b0, 1'b0, 1'b0, 1'b0);
        if (ri) check("hdr.lpv", 32'(lpv_x), 32'd0);
        lfd_state = 1'b1;
        tick;
        lfd_state = 1'b0;
        check("lfd.dout_x", 32'(dout_x), 32'(ed));
        check("lfd.dout_s", 32'(dout_s), 32'(ed));
    endtask

    task automatic payload(input int n, input int st);
        for (int i = 0; i < n; i++) begin
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = pl[i];
            fifo_full = (i == st);
            tick;
            if (i == st) begin
                check("stall.dout", 32'(dout_x), 32'(pl[i-1]));
                ld_state   = 1'b0;
                fifo_full  = 1'b0;
                full_state = 1'b1;
                tick;
                full_state = 1'b0;
                laf_state  = 1'b1;
                tick;
                laf_state  = 1'b0;
            end
            check("pay.dout_x", 32'(dout_x), 32'(pl[i]));
            check("pay.dout_s", 32'(dout_s), 32'(pl[i]));
        end
    endtask

    task automatic chkbyte(input logic [7:0] c, input logic st);
        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = c;
        fifo_full = st;
        tick;
        ld_state  = 1'b0;
        fifo_full = 1'b0;
        if (st) begin
            check("cstall.pd", 32'(pd_x), 32'd0);
            full_state = 1'b1;
            tick;
            full_state = 1'b0;
            laf_state  = 1'b1;
            tick;
            laf_state  = 1'b0;
        end
        check("chk.dout", 32'(dout_x), 32'(c));
        check("chk.lpv", 32'(lpv_x), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        tick;
        check("rst.dout", 32'(dout_x), 32'd0);
        check("rst.len", 32'(len_x), 32'd0);
        check("rst.lpv", 32'(lpv_x), 32'd0);
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) pl[i] = 8'(17 * (i + 1));

        // XOR 0x07 good, SUM 0x15 differs
        hdr(8'h16, 1'b0, 6'd5, 8'h16);
        payload(5, -1);
        chkbyte(8'h07, 1'b0);
        flags("p1", 1'b1, 1'b0, 1'b1, 1'b0);

        hdr(8'h16, 1'b1, 6'd5, 8'h16);
        payload(5, -1);
        chkbyte(8'h08, 1'b0);
        flags("p2", 1'b1, 1'b1, 1'b1, 1'b0);

        hdr(8'h16, 1'b1, 6'd5, 8'h16);
        payload(5, -1);
        chkbyte(8'h15, 1'b0);
        flags("p3", 1'b1, 1'b1, 1'b0, 1'b0);

        rst_int_reg = 1'b1;
        tick;
        rst_int_reg = 1'b0;
        check("ri.lpv_x", 32'(lpv_x), 32'd0);
        check("ri.lpv_s", 32'(lpv_s), 32'd0);
        check("ri.pd", 32'(pd_x), 32'd1);

        // Length 10 header, 9 payload bytes
        for (int i = 0; i < 9; i++) pl[i] = 8'(i + 1);
        hdr(8'h29, 1'b1, 6'd10, 8'h29);
        payload(9, -1);
        chkbyte(8'h28, 1'b0);
        flags("p4", 1'b1, 1'b0, 1'b1, 1'b1);

        // Address 3 is invalid: header and length kept
        hdr(8'h1B, 1'b1, 6'd10, 8'h29);

        for (int i = 0; i < 5; i++) pl[i] = 8'(17 * (i + 1));
        hdr(8'h16, 1'b1, 6'd5, 8'h16);
        payload(5, 2);
        chkbyte(8'h07, 1'b0);
        flags("p5", 1'b1, 1'b0, 1'b1, 1'b0);

        hdr(8'h16, 1'b1, 6'd5, 8'h16);
        payload(5, -1);
        chkbyte(8'h07, 1'b1);
        flags("p6", 1'b1, 1'b0, 1'b1, 1'b0);

        hdr(8'h02, 1'b1, 6'd0, 8'h02);
        chkbyte(8'h02, 1'b0);
        flags("p7", 1'b1, 1'b0, 1'b0, 1'b0);

        hdr(8'h16, 1'b0, 6'd5, 8'h16);
        payload(2, -1);
        check("pre.lpv", 32'(lpv_x), 32'd1);
        ld_state  = 1'b1;
        pkt_valid = 1'b1;
        data_in   = 8'h33;
        #1;
        reset = 1'b0;
        #1;
        check("mid.dout_x", 32'(dout_x), 32'd0);
        check("mid.dout_s", 32'(dout_s), 32'd0);
        check("mid.len", 32'(len_x), 32'd0);
        check("mid.lpv", 32'(lpv_x), 32'd0);
        flags("mid", 1'b0, 1'b0, 1'b0, 1'b0);
        ld_state  = 1'b0;
        pkt_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
